// File: rtl/dac_arbiter_if.sv
// Bundle between the requesters, the serial DAC driver and dac_arbiter.
// master = requesters/driver side, slave = the arbiter.
interface dac_arbiter_if #(
    parameter int NREQ = 4,
    parameter int SW   = 12
);
    logic [NREQ-1:0]    req;
    logic [NREQ*SW-1:0] sample;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic [1:0]         grant_ch;
    logic               dac_en;
    logic [15:0]        dac_data;
    logic               dac_cvt_done;
    logic               err;

    modport master (
        output req, sample, dac_cvt_done,
        input  ack, busy, grant_ch, dac_en, dac_data, err
    );

    modport slave (
        input  req, sample, dac_cvt_done,
        output ack, busy, grant_ch, dac_en, dac_data, err
    );
endinterface

// File: rtl/dac_arbiter.sv
// Round-robin arbiter sharing one serial DAC driver among NREQ requesters.
// Optional driver watchdog enabled by defining DAC_ARB_TIMEOUT_EN.
module dac_arbiter #(
    parameter int NREQ           = 4,
    parameter int SW             = 12,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    dac_arbiter_if.slave  io_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t          r_state, w_next_state;
    logic [1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic            r_done_q;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic            r_busy;
    logic [1:0]      r_grant_ch, w_grant_ch_nxt;
    logic            r_dac_en, w_dac_en_nxt;
    logic [15:0]     r_dac_data, w_dac_data_nxt;
    logic            r_err, w_err_nxt;

    logic            w_any_req;
    logic            w_done_rise;
    logic            w_wd_expired;
    logic [1:0]      w_winner;
    logic [SW-1:0]   w_sample;

    assign w_any_req   = |io_bus.req;
    assign w_done_rise = io_bus.dac_cvt_done & ~r_done_q;

    // NREQ is fixed at 4, so the 2-bit sum wraps from NREQ-1 back to 0 by itself.
    // Scanning offsets downward leaves the nearest set bit above the pointer as winner.
    always_comb begin
        w_winner = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (io_bus.req[r_rr_ptr + 2'(k)]) begin
                w_winner = r_rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == 2'(k)) begin
                w_sample = io_bus.sample[k*SW +: SW];
            end
        end
    end

`ifdef DAC_ARB_TIMEOUT_EN
    logic [15:0] r_wd_cnt;

    // Held at zero outside WAIT, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    assign w_wd_expired = (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_wd_expired     = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_ack_nxt      = '0;
        w_grant_ch_nxt = r_grant_ch;
        w_dac_en_nxt   = 1'b0;
        w_dac_data_nxt = r_dac_data;
        w_err_nxt      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ARB;
                end
            end

            S_ARB: begin
                if (w_any_req) begin
                    w_grant_ch_nxt = w_winner;
                    w_dac_data_nxt = {w_winner, 2'b00, w_sample};
                    w_next_state   = S_START;
                end else begin
                    w_next_state   = S_IDLE;
                end
            end

            S_START: begin
                w_dac_en_nxt = 1'b1;
                w_next_state = S_WAIT;
            end

            S_WAIT: begin
                // A done edge coinciding with the watchdog limit is a success.
                if (w_done_rise || w_wd_expired) begin
                    w_ack_nxt[r_grant_ch] = 1'b1;
                    w_err_nxt             = w_wd_expired & ~w_done_rise;
                    w_rr_ptr_nxt          = r_grant_ch + 2'd1;
                    w_gap_cnt_nxt         = 8'(GAP_CYCLES);
                    w_next_state          = S_GAP;
                end
            end

            S_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_next_state  = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_gap_cnt  <= '0;
            r_done_q   <= 1'b0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_grant_ch <= '0;
            r_dac_en   <= 1'b0;
            r_dac_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_done_q   <= io_bus.dac_cvt_done;
            r_ack      <= w_ack_nxt;
            r_busy     <= (w_next_state != S_IDLE);
            r_grant_ch <= w_grant_ch_nxt;
            r_dac_en   <= w_dac_en_nxt;
            r_dac_data <= w_dac_data_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign io_bus.ack      = r_ack;
    assign io_bus.busy     = r_busy;
    assign io_bus.grant_ch = r_grant_ch;
    assign io_bus.dac_en   = r_dac_en;
    assign io_bus.dac_data = r_dac_data;
    assign io_bus.err      = r_err;

endmodule

// File: tb/tb_dac_arbiter.sv
// Self-checking bench for dac_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free round-robin reference model.
module tb_dac_arbiter;

    localparam int NREQ           = 4;
    localparam int SW             = 12;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 32;
`ifdef DAC_ARB_TIMEOUT_EN
    localparam int SINGLE_DLY     = 20;
`else
    localparam int SINGLE_DLY     = 66;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: pending requests, per-requester samples, rr pointer.
    logic [3:0]  m_req;
    logic [11:0] m_sample [4];
    int          m_ptr;

    dac_arbiter_if #(.NREQ(NREQ), .SW(SW)) bus ();

    dac_arbiter #(
        .NREQ           (NREQ),
        .SW             (SW),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish, observed running, expected done");
        $fatal(1, "bench time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic drive();
        bus.req = m_req;
        for (int i = 0; i < 4; i++) bus.sample[i*SW +: SW] = m_sample[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_ack", tag),      bus.ack,      32'h0);
        check($sformatf("%s_busy", tag),     bus.busy,     32'h0);
        check($sformatf("%s_grant", tag),    bus.grant_ch, 32'h0);
        check($sformatf("%s_dac_en", tag),   bus.dac_en,   32'h0);
        check($sformatf("%s_dac_data", tag), bus.dac_data, 32'h0);
        check($sformatf("%s_err", tag),      bus.err,      32'h0);
    endtask

    task automatic wait_dac_en(output int cyc);
        logic stray;
        stray = 1'b0;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.ack !== 4'b0000) stray = 1'b1;
        end while (bus.dac_en !== 1'b1 && cyc < 100);
        check("dac_en_seen", bus.dac_en, 32'h1);
        check("no_ack_before_dac_en", stray, 32'h0);
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.ack === 4'b0000 && cyc < 200);
        check("ack_seen", (bus.ack !== 4'b0000), 32'h1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.busy !== 1'b0 && cyc < 50);
        check("idle_reached", bus.busy, 32'h0);
    endtask

    // One complete transfer: the driver model raises done `delay` cycles after dac_en.
    task automatic run_transfer(input int delay, input string tag, output int lat);
        int   win;
        int   exp_data;
        logic early;
        win      = rr_pick(m_req, m_ptr);
        exp_data = (win << 14) | int'(m_sample[win]);
        wait_dac_en(lat);
        check($sformatf("%s_grant", tag), bus.grant_ch, win);
        check($sformatf("%s_data", tag),  bus.dac_data, exp_data);
        early = 1'b0;
        repeat (delay) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000 || bus.err !== 1'b0 || bus.dac_data !== 16'(exp_data)) early = 1'b1;
        end
        check($sformatf("%s_quiet_in_wait", tag), early, 32'h0);
        bus.dac_cvt_done = 1'b1;
        @(negedge clk);
        check($sformatf("%s_ack", tag), bus.ack, 32'(1 << win));
        check($sformatf("%s_err", tag), bus.err, 32'h0);
        bus.dac_cvt_done = 1'b0;
        m_ptr      = (win + 1) % 4;
        m_req[win] = 1'b0;
        drive();
    endtask

    initial begin
        int         lat;
        int         cyc;
        int         win;
        logic       seen;
        logic [3:0] newbits;

        rst              = 1'b1;
        bus.dac_cvt_done = 1'b0;
        m_req            = 4'b0000;
        m_ptr            = 0;
        for (int i = 0; i < 4; i++) m_sample[i] = 12'($urandom);
        drive();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single request, no contention.
        m_sample[2] = 12'hABC;
        m_req       = 4'b0100;
        drive();
        run_transfer(SINGLE_DLY, "single", lat);
        check("single_latency", lat, 32'd3);
        check("single_data_const", bus.dac_data, 32'h8ABC);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.busy !== 1'b0 && cyc < 20);
        check("single_busy_low_after_ack", cyc, GAP_CYCLES + 1);

        // Round-robin order from a fresh reset with every requester held high.
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            m_req = 4'b1111;
            drive();
            run_transfer(int'($urandom_range(1, 10)), "rr", lat);
            check("rr_order", bus.grant_ch, i % 4);
        end
        m_req = 4'b0000;
        drive();
        wait_idle();

        // Stale done level must not complete the transfer.
        bus.dac_cvt_done = 1'b1;
        @(negedge clk);
        m_req = 4'b0001;
        drive();
        win = rr_pick(m_req, m_ptr);
        wait_dac_en(lat);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ack !== 4'b0000) seen = 1'b1;
        end
        check("stale_no_ack", seen, 32'h0);
        bus.dac_cvt_done = 1'b0;
        @(negedge clk);
        bus.dac_cvt_done = 1'b1;
        @(negedge clk);
        check("stale_fresh_edge_ack", bus.ack, 32'(1 << win));
        bus.dac_cvt_done = 1'b0;
        m_ptr = (win + 1) % 4;
        m_req = 4'b0000;
        drive();
        wait_idle();

        // Request withdrawn while the arbiter is in ARB.
        m_req = 4'b0010;
        drive();
        @(negedge clk);
        check("withdraw_busy_in_arb", bus.busy, 32'h1);
        m_req = 4'b0000;
        drive();
        @(negedge clk);
        check("withdraw_back_to_idle", bus.busy, 32'h0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.dac_en !== 1'b0 || bus.ack !== 4'b0000) seen = 1'b1;
        end
        check("withdraw_nothing_issued", seen, 32'h0);

        // Unresponsive driver.
        m_req = 4'b0110;
        drive();
`ifdef DAC_ARB_TIMEOUT_EN
        win = rr_pick(m_req, m_ptr);
        wait_dac_en(lat);
        check("wd_grant", bus.grant_ch, win);
        wait_ack(cyc);
        check("wd_abort_cycles", cyc, TIMEOUT_CYCLES);
        check("wd_ack", bus.ack, 32'(1 << win));
        check("wd_err", bus.err, 32'h1);
        m_ptr      = (win + 1) % 4;
        m_req[win] = 1'b0;
        drive();
        @(negedge clk);
        check("wd_err_one_cycle", bus.err, 32'h0);
        check("wd_ack_one_cycle", bus.ack, 32'h0);
        run_transfer(5, "wd_next", lat);
`else
        run_transfer(60, "no_wd_hold", lat);
        run_transfer(5, "no_wd_next", lat);
`endif

        // Randomized traffic against the reference model.
        for (int r = 0; r < 12; r++) begin
            newbits = 4'($urandom_range(0, 15)) & ~m_req;
            if ((m_req | newbits) == 4'b0000) newbits = 4'(1 << $urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                if (newbits[i]) m_sample[i] = 12'($urandom);
            end
            m_req = m_req | newbits;
            drive();
            run_transfer(int'($urandom_range(1, 20)), "rand", lat);
        end

        // Reset in the middle of WAIT.
        m_req = 4'b1000;
        drive();
        win = rr_pick(m_req, m_ptr);
        wait_dac_en(lat);
        check("rstwait_grant_before", bus.grant_ch, win);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        m_ptr       = 0;
        m_req       = 4'b0001;
        m_sample[0] = 12'($urandom);
        drive();
        rst = 1'b0;
        run_transfer(8, "post_rst", lat);
        check("post_rst_latency", lat, 32'd3);

        m_req = 4'b0000;
        drive();
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
